// File: rtl/rsa_pkg.sv
// Shared RSA core definitions: default operand/exponent widths and the
// modular-exponentiation controller state encoding.
package rsa_pkg;

  localparam int unsigned WIDTH = 256;
  localparam int unsigned K     = 256;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL_CHK,
    S_MUL_REQ,
    S_MUL_WAIT,
    S_SQR_CHK,
    S_SQR_REQ,
    S_SQR_WAIT,
    S_DONE
  } mexp_state_t;

endpackage

// File: rtl/mod_exp_controller.sv
// Right-to-left binary exponentiation controller: drives one shared
// modular-multiply engine to compute o_result = i_a^i_d mod i_n.
module mod_exp_controller
  import rsa_pkg::*;
#(
  parameter int unsigned WIDTH = rsa_pkg::WIDTH,
  parameter int unsigned K     = rsa_pkg::K
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [K-1:0]     i_d,
  input  logic [WIDTH-1:0] i_n,
  output logic [WIDTH-1:0] o_result,
  output logic             o_finish,
  output logic             o_busy,
  output logic             o_mp_start,
  output logic [WIDTH-1:0] o_mp_a,
  output logic [WIDTH-1:0] o_mp_b,
  output logic [WIDTH-1:0] o_mp_n,
  input  logic [WIDTH-1:0] i_mp_result,
  input  logic             i_mp_finish
);

  localparam int unsigned CW = (K > 1) ? $clog2(K) : 1;

  mexp_state_t      state;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] n_q;
  logic [K-1:0]     e_q;
  logic [CW-1:0]    cnt_q;

  // Request pulses and operands are registered on entry to a REQ state and
  // left untouched until the next request, so they stay stable through WAIT.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      t_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      e_q        <= '0;
      cnt_q      <= '0;
      o_result   <= '0;
      o_finish   <= 1'b0;
      o_busy     <= 1'b0;
      o_mp_start <= 1'b0;
      o_mp_a     <= '0;
      o_mp_b     <= '0;
      o_mp_n     <= '0;
    end else begin
      o_mp_start <= 1'b0;
      o_finish   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_start) begin
            t_q    <= i_a;
            e_q    <= i_d;
            n_q    <= i_n;
            m_q    <= (i_n == WIDTH'(1)) ? '0 : WIDTH'(1);
            cnt_q  <= '0;
            o_busy <= 1'b1;
            state  <= S_MUL_CHK;
          end
        end
        S_MUL_CHK: begin
          if (e_q[cnt_q]) begin
            o_mp_a     <= m_q;
            o_mp_b     <= t_q;
            o_mp_n     <= n_q;
            o_mp_start <= 1'b1;
            state      <= S_MUL_REQ;
          end else begin
            state <= S_SQR_CHK;
          end
        end
        S_MUL_REQ: state <= S_MUL_WAIT;
        S_MUL_WAIT: begin
          if (i_mp_finish) begin
            m_q   <= i_mp_result;
            state <= S_SQR_CHK;
          end
        end
        // The square after the last exponent bit would be wasted work.
        S_SQR_CHK: begin
          if (cnt_q == CW'(K - 1)) begin
            o_result <= m_q;
            o_finish <= 1'b1;
            state    <= S_DONE;
          end else begin
            o_mp_a     <= t_q;
            o_mp_b     <= t_q;
            o_mp_n     <= n_q;
            o_mp_start <= 1'b1;
            state      <= S_SQR_REQ;
          end
        end
        S_SQR_REQ: state <= S_SQR_WAIT;
        S_SQR_WAIT: begin
          if (i_mp_finish) begin
            t_q   <= i_mp_result;
            cnt_q <= cnt_q + CW'(1);
            state <= S_MUL_CHK;
          end
        end
        S_DONE: begin
          o_busy <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_exp_controller.sv
// Bench for mod_exp_controller with a behavioural multiply engine of
// configurable latency; directed vectors plus reset/spurious-finish sequences.
module tb_mod_exp_controller;

  localparam int unsigned W  = 16;
  localparam int unsigned KB = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [W-1:0]  a;
  logic [KB-1:0] d;
  logic [W-1:0]  n;
  logic [W-1:0]  result;
  logic          finish;
  logic          busy;
  logic          mp_start;
  logic [W-1:0]  mp_a;
  logic [W-1:0]  mp_b;
  logic [W-1:0]  mp_n;
  logic [W-1:0]  mp_result;
  logic          mp_finish;

  int total = 0;
  int bad   = 0;

  // Engine-owned monitors (only the engine process writes these)
  int req_cnt      = 0;
  int nonsq_cnt    = 0;
  int fin_cnt      = 0;
  int unstable_cnt = 0;
  int overlap_cnt  = 0;
  int spur_idle_done = 0;
  int spur_chk_done  = 0;

  // Main-process controls read by the engine
  int lat_fixed = 1;
  bit lat_rand  = 1'b0;
  int spur_idle_req = 0;
  int spur_chk_req  = 0;

  always #5 clk = ~clk;

  mod_exp_controller #(.WIDTH(W), .K(KB)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_start     (start),
    .i_a         (a),
    .i_d         (d),
    .i_n         (n),
    .o_result    (result),
    .o_finish    (finish),
    .o_busy      (busy),
    .o_mp_start  (mp_start),
    .o_mp_a      (mp_a),
    .o_mp_b      (mp_b),
    .o_mp_n      (mp_n),
    .i_mp_result (mp_result),
    .i_mp_finish (mp_finish)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural multiply engine; also monitors request/operand protocol.
  initial begin : engine
    bit             pending;
    int             lat_cnt;
    logic [W-1:0]   la, lb, ln;
    logic [2*W-1:0] prod;
    pending   = 1'b0;
    lat_cnt   = 0;
    la = '0; lb = '0; ln = '0;
    mp_finish = 1'b0;
    mp_result = '0;
    forever begin
      @(posedge clk);
      #1;
      mp_finish = 1'b0;
      if (!rst_n) begin
        pending = 1'b0;
        continue;
      end
      if (finish) fin_cnt++;
      if (pending) begin
        if (mp_a !== la || mp_b !== lb || mp_n !== ln) unstable_cnt++;
        if (lat_cnt == 0) begin
          prod      = (2*W)'(la) * (2*W)'(lb);
          mp_result = W'(prod % (2*W)'(ln));
          mp_finish = 1'b1;
          pending   = 1'b0;
        end else begin
          lat_cnt--;
        end
      end else if (spur_idle_req > spur_idle_done && !busy) begin
        mp_result = '0;
        mp_finish = 1'b1;
        spur_idle_done++;
      end else if (spur_chk_req > spur_chk_done && busy) begin
        mp_result = '0;
        mp_finish = 1'b1;
        spur_chk_done++;
      end
      if (mp_start) begin
        if (pending) overlap_cnt++;
        req_cnt++;
        if (mp_a !== mp_b) nonsq_cnt++;
        pending = 1'b1;
        la = mp_a; lb = mp_b; ln = mp_n;
        lat_cnt = (lat_rand ? int'($urandom_range(300, 1)) : lat_fixed) - 1;
      end
    end
  end

  // One operation: start in the current (idle) cycle, wait for o_finish,
  // check busy/result hold in the following idle cycle. Returns at posedge+3.
  task automatic run_op(input logic [W-1:0] ta, input logic [KB-1:0] td,
                        input logic [W-1:0] tn, input bit mid_start,
                        input string tag, output logic [W-1:0] res,
                        output int reqs, output int nonsq);
    int  r0, q0, f0, u0, o0;
    bit  done;
    r0 = req_cnt; q0 = nonsq_cnt; f0 = fin_cnt; u0 = unstable_cnt; o0 = overlap_cnt;
    a = ta; d = td; n = tn; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    done = 1'b0;
    for (int c = 0; c < 20000 && !done; c++) begin
      if (finish) begin
        done = 1'b1;
      end else begin
        if (mid_start && c == 5) begin
          a = W'(3); d = 8'hFF; n = W'(1000); start = 1'b1;
        end else begin
          start = 1'b0;
        end
        @(posedge clk);
        #1;
      end
    end
    start = 1'b0;
    chk({tag, " finished_in_time"}, 64'(done), 64'd1);
    chk({tag, " busy_in_finish_cycle"}, 64'(busy), 64'd1);
    res = result;
    @(posedge clk);
    #3;
    chk({tag, " busy_low_after"}, 64'(busy), 64'd0);
    chk({tag, " result_held"}, 64'(result), 64'(res));
    chk({tag, " finish_pulses"}, 64'(fin_cnt - f0), 64'd1);
    chk({tag, " operand_unstable"}, 64'(unstable_cnt - u0), 64'd0);
    chk({tag, " overlap_requests"}, 64'(overlap_cnt - o0), 64'd0);
    reqs  = req_cnt - r0;
    nonsq = nonsq_cnt - q0;
  endtask

  typedef struct {
    logic [W-1:0]  a;
    logic [KB-1:0] d;
    logic [W-1:0]  n;
    int            lat;      // 0 selects random latency 1..300
    bit            chk_nonsq;
    logic [W-1:0]  exp_res;
    int            exp_reqs;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] res;
    int           reqs, nonsq, r0;
    bit           hit;

    vecs[0] = '{a: 16'd4, d: 8'd13,  n: 16'd497,  lat: 3, chk_nonsq: 1'b0, exp_res: 16'd445, exp_reqs: 10};
    vecs[1] = '{a: 16'd2, d: 8'd255, n: 16'd1000, lat: 0, chk_nonsq: 1'b0, exp_res: 16'd968, exp_reqs: 15};
    vecs[2] = '{a: 16'd5, d: 8'd0,   n: 16'd7,    lat: 2, chk_nonsq: 1'b1, exp_res: 16'd1,   exp_reqs: 7};
    vecs[3] = '{a: 16'd3, d: 8'd1,   n: 16'd5,    lat: 1, chk_nonsq: 1'b0, exp_res: 16'd3,   exp_reqs: 8};
    vecs[4] = '{a: 16'd0, d: 8'd5,   n: 16'd11,   lat: 4, chk_nonsq: 1'b0, exp_res: 16'd0,   exp_reqs: 9};
    vecs[5] = '{a: 16'd7, d: 8'd128, n: 16'd13,   lat: 1, chk_nonsq: 1'b0, exp_res: 16'd3,   exp_reqs: 8};
    vecs[6] = '{a: 16'd6, d: 8'd2,   n: 16'd10,   lat: 2, chk_nonsq: 1'b0, exp_res: 16'd6,   exp_reqs: 8};
    vecs[7] = '{a: 16'd9, d: 8'd0,   n: 16'd1,    lat: 1, chk_nonsq: 1'b1, exp_res: 16'd0,   exp_reqs: 7};

    rst_n = 1'b0; start = 1'b0; a = '0; d = '0; n = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset result",   64'(result),   64'd0);
    chk("reset finish",   64'(finish),   64'd0);
    chk("reset busy",     64'(busy),     64'd0);
    chk("reset mp_start", 64'(mp_start), 64'd0);
    chk("reset mp_ops",   64'({mp_a, mp_b, mp_n}), 64'd0);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #3;

    // Directed vectors, issued back-to-back
    foreach (vecs[i]) begin
      lat_rand  = (vecs[i].lat == 0);
      lat_fixed = (vecs[i].lat == 0) ? 1 : vecs[i].lat;
      run_op(vecs[i].a, vecs[i].d, vecs[i].n, 1'b0, $sformatf("vec%0d", i), res, reqs, nonsq);
      chk($sformatf("vec%0d result", i),   64'(res),  64'(vecs[i].exp_res));
      chk($sformatf("vec%0d requests", i), 64'(reqs), 64'(vecs[i].exp_reqs));
      if (vecs[i].chk_nonsq) chk($sformatf("vec%0d mul_requests", i), 64'(nonsq), 64'd0);
    end

    // n = 1 with a second start pulsed mid-operation
    lat_rand = 1'b0; lat_fixed = 2;
    run_op(16'd0, 8'd200, 16'd1, 1'b1, "midstart", res, reqs, nonsq);
    chk("midstart result",   64'(res),  64'd0);
    chk("midstart requests", 64'(reqs), 64'd10);

    // Spurious engine finish while idle, then during S_MUL_CHK
    lat_fixed = 3;
    run_op(16'd4, 16'd13, 16'd497, 1'b0, "pre_spur", res, reqs, nonsq);
    r0 = req_cnt;
    spur_idle_req++;
    repeat (3) @(posedge clk);
    #3;
    chk("spur_idle busy",     64'(busy),          64'd0);
    chk("spur_idle result",   64'(result),        64'd445);
    chk("spur_idle requests", 64'(req_cnt - r0),  64'd0);
    spur_chk_req++;
    run_op(16'd4, 8'd13, 16'd497, 1'b0, "spur_chk", res, reqs, nonsq);
    chk("spur_chk result",   64'(res),  64'd445);
    chk("spur_chk requests", 64'(reqs), 64'd10);
    run_op(16'd2, 8'd255, 16'd1000, 1'b0, "b2b", res, reqs, nonsq);
    chk("b2b result", 64'(res), 64'd968);

    // Asynchronous reset during the first squaring wait of 4^13 mod 497
    lat_fixed = 3;
    r0 = req_cnt;
    a = 16'd4; d = 8'd13; n = 16'd497; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      @(posedge clk);
      #2;
      if (req_cnt - r0 >= 2) hit = 1'b1;
    end
    chk("rst reached sqr", 64'(hit), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("rst result",   64'(result),   64'd0);
    chk("rst finish",   64'(finish),   64'd0);
    chk("rst busy",     64'(busy),     64'd0);
    chk("rst mp_start", 64'(mp_start), 64'd0);
    chk("rst mp_ops",   64'({mp_a, mp_b, mp_n}), 64'd0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #3;
    run_op(16'd4, 8'd13, 16'd497, 1'b0, "post_rst", res, reqs, nonsq);
    chk("post_rst result",   64'(res),  64'd445);
    chk("post_rst requests", 64'(reqs), 64'd10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_exp_controller.md
Name: mod_exp_controller

Overview:
- Sequences one shared modular-multiply engine (a*b mod n, start/finish handshake) to compute o_result = i_a^i_d mod i_n.
- Uses right-to-left binary exponentiation.
- Sits in the RSA core between the top-level RSA wrapper and the single multiply engine. It owns every engine request, so the engine needs no arbitration.

Parameters:
- WIDTH, 256, bit width of base, modulus, result and engine operands.
- K, 256, number of exponent bits processed (i_d width).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle request; sampled only in S_IDLE.
- i_a  in  WIDTH  base; caller guarantees i_a < i_n.
- i_d  in  K  exponent.
- i_n  in  WIDTH  modulus, >= 1.
- o_result  out  WIDTH  i_a^i_d mod i_n, valid from o_finish until next accepted start.
- o_finish  out  1  one-cycle completion pulse.
- o_busy  out  1  high from the cycle after start acceptance until the o_finish cycle inclusive.
- o_mp_start  out  1  one-cycle engine request pulse.
- o_mp_a  out  WIDTH  engine operand a.
- o_mp_b  out  WIDTH  engine operand b.
- o_mp_n  out  WIDTH  engine modulus.
- i_mp_result  in  WIDTH  engine product, valid when i_mp_finish = 1.
- i_mp_finish  in  1  engine one-cycle done pulse; latency arbitrary (>= 1 cycle).

Behaviour:
- Clock and reset: one clock; asynchronous active-low reset i_rst_n.
- Reset values: o_result = 0, o_finish = 0, o_busy = 0, o_mp_start = 0, o_mp_a/b/n = 0, state = S_IDLE, bit counter = 0.
- Start acceptance:
  - i_start in S_IDLE latches i_a into T, i_d into E and i_n into N.
  - M is initialised to (i_n == 1) ? 0 : 1; counter is set to 0; next state is S_MUL_CHK.
  - i_start in any other state is ignored.
- State machine:
  - S_IDLE -> S_MUL_CHK on i_start.
  - S_MUL_CHK: if E[cnt] = 1, go to S_MUL_REQ; else go to S_SQR_CHK.
  - S_MUL_REQ: drive o_mp_a = M, o_mp_b = T, o_mp_n = N, o_mp_start = 1 for exactly this cycle; go to S_MUL_WAIT.
  - S_MUL_WAIT: hold operands stable; on i_mp_finish, M <= i_mp_result and go to S_SQR_CHK.
  - S_SQR_CHK: if cnt == K-1, go to S_DONE (no final squaring); else go to S_SQR_REQ.
  - S_SQR_REQ: operands T, T, N; o_mp_start = 1 for one cycle; go to S_SQR_WAIT.
  - S_SQR_WAIT: on i_mp_finish, T <= i_mp_result, cnt <= cnt + 1, go to S_MUL_CHK.
  - S_DONE: o_result <= M, o_finish = 1 for this cycle only; next state S_IDLE.
- Engine request count per operation: popcount(i_d) + (K-1) exactly. Exactly one o_mp_start per request; never two requests outstanding.
- Engine operands are held stable from the REQ cycle through the cycle i_mp_finish is seen.
- i_mp_finish outside the WAIT states is ignored. A finish in the same cycle as o_mp_start is impossible given the minimum latency of 1 and is not handled.
- Counter width is $clog2(K), compared against K-1. No wrap-around is possible because S_SQR_CHK exits at K-1.
- Boundary results:
  - i_d = 0 gives result 1 (0 if i_n = 1).
  - i_a = 0 with i_d != 0 gives 0.
  - i_n = 1 always gives 0.
- o_result holds its value after o_finish until the next accepted start; it is not cleared in S_IDLE.
- Reset mid-operation:
  - All state returns to reset values immediately and asynchronously.
  - The engine shares i_rst_n, so any in-flight engine result is discarded.
  - The first i_start after reset release is accepted normally.

Decomposition:
- Shared package rsa_pkg: WIDTH and K localparams, plus typedef enum mexp_state_t {S_IDLE, S_MUL_CHK, S_MUL_REQ, S_MUL_WAIT, S_SQR_CHK, S_SQR_REQ, S_SQR_WAIT, S_DONE}.
- No sub-module. The controller is a single FSM plus operand registers. The multiply engine is instantiated beside it by the RSA core, not inside it.

Test Plan:
1. K=8, i_a=4, i_d=13, i_n=497, engine latency 3 -> o_result=445, o_finish one pulse, exactly 10 o_mp_start pulses (3 mul, 7 sqr).
2. K=8, i_a=2, i_d=255, i_n=1000, random engine latency 1..300 -> o_result=968, 15 requests, operands stable throughout every wait.
3. K=8, i_d=0, i_a=5, i_n=7 -> o_result=1, 7 requests, zero mul-type requests (o_mp_a never equals M while o_mp_b equals T outside squaring).
4. i_n=1, i_a=0, i_d=200 -> o_result=0; start pulsed again mid-operation -> ignored, request count unchanged.
5. Assert i_rst_n=0 during S_SQR_WAIT of scenario 1 -> all outputs 0 in the same cycle; after release, rerun scenario 1 -> 445.
6. Spurious i_mp_finish pulses in S_IDLE and S_MUL_CHK -> no state or M/T change; back-to-back starts immediately after o_finish both complete correctly.
